// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the iterative multiply/divide unit (muldiv_hilo):
//   - operation encodings OP_MULT / OP_MULTU / OP_DIV / OP_DIVU
//   - controller state encoding ST_IDLE / ST_RUN / ST_FIX
//   - small opcode decode helpers
// -----------------------------------------------------------------------------
package muldiv_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10
    } state_t;

    // Signed operations take operand magnitudes and sign-correct the result.
    function automatic logic op_is_signed(input logic [1:0] op);
        logic s;
        s = 1'b0;
        case (op)
            OP_MULT:  s = 1'b1;
            OP_MULTU: s = 1'b0;
            OP_DIV:   s = 1'b1;
            OP_DIVU:  s = 1'b0;
            default:  s = 1'b0;
        endcase
        return s;
    endfunction

    function automatic logic op_is_div(input logic [1:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_abs.sv
// -----------------------------------------------------------------------------
// muldiv_abs
// Conditional two's-complement negate. Used both to take operand magnitudes
// at launch and to apply sign correction to the results.
// Ports:
//   val_i [WIDTH-1:0]  value in
//   neg_i              1 = negate, 0 = pass through
//   res_o [WIDTH-1:0]  result
// -----------------------------------------------------------------------------
module muldiv_abs
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] val_i,
    input  logic             neg_i,
    output logic [WIDTH-1:0] res_o
);

    assign res_o = neg_i ? (~val_i + 1'b1) : val_i;

endmodule

// File: rtl/muldiv_hilo.sv
// -----------------------------------------------------------------------------
// muldiv_hilo
// Iterative multiply/divide unit owning the MIPS HI/LO registers.
// MULT/MULTU: radix-2 shift-add, one multiplier bit per RUN cycle.
// DIV/DIVU:   restoring division, one quotient bit per RUN cycle.
// Fixed latency WIDTH+1 cycles (WIDTH RUN cycles + 1 FIX cycle).
// Optional build macro MULDIV_EARLY_EXIT_EN: multiply leaves RUN once the
// remaining multiplier bits are zero, divide-by-zero leaves RUN after one
// cycle. Results are identical with or without it.
// Ports:
//   Clk, Reset (async, active-low)
//   start, op[1:0], a, b      operation launch (sampled in IDLE only)
//   wr_hi, wr_lo, wr_data     MTHI/MTLO direct writes (IDLE only)
//   busy                      high in RUN or FIX
//   done                      one-cycle pulse after the result is written
//   hi, lo                    HI/LO architectural registers
// -----------------------------------------------------------------------------
module muldiv_hilo
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t               state_q, state_d;
    logic [1:0]           op_q, op_d;
    // opa: multiplicand shifted left (mul) / dividend->quotient shifter in low half (div)
    logic [2*WIDTH-1:0]   opa_q, opa_d;
    // opb: multiplier shifted right (mul) / divisor, held constant (div)
    logic [WIDTH-1:0]     opb_q, opb_d;
    // acc: product (mul) / partial remainder in acc[WIDTH:0] (div)
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     araw_q, araw_d;
    logic                 neg_res_q, neg_res_d;
    logic                 neg_rem_q, neg_rem_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
    logic                 done_q, done_d;

    logic                 sgn_launch;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo_fix, rem_fix;
    logic                 is_div;
    logic                 early_exit;
    logic [WIDTH:0]       shifted;
    logic [WIDTH+1:0]     trial;

    assign sgn_launch = op_is_signed(op);
    assign is_div     = op_is_div(op_q);

    muldiv_abs #(.WIDTH(WIDTH)) u_abs_a (
        .val_i (a),
        .neg_i (sgn_launch & a[WIDTH-1]),
        .res_o (a_mag)
    );

    muldiv_abs #(.WIDTH(WIDTH)) u_abs_b (
        .val_i (b),
        .neg_i (sgn_launch & b[WIDTH-1]),
        .res_o (b_mag)
    );

    muldiv_abs #(.WIDTH(2*WIDTH)) u_neg_prod (
        .val_i (acc_q),
        .neg_i (neg_res_q),
        .res_o (prod_fix)
    );

    muldiv_abs #(.WIDTH(WIDTH)) u_neg_quo (
        .val_i (opa_q[WIDTH-1:0]),
        .neg_i (neg_res_q),
        .res_o (quo_fix)
    );

    muldiv_abs #(.WIDTH(WIDTH)) u_neg_rem (
        .val_i (acc_q[WIDTH-1:0]),
        .neg_i (neg_rem_q),
        .res_o (rem_fix)
    );

    // Restoring-division trial subtract; the extra top bit is the borrow.
    assign shifted = {acc_q[WIDTH-1:0], opa_q[WIDTH-1]};
    assign trial   = {1'b0, shifted} - {2'b00, opb_q};

`ifdef MULDIV_EARLY_EXIT_EN
    // Multiply: after this cycle's shift, nothing left to add.
    // Divide by zero: result is forced in FIX, so the iterations are moot.
    assign early_exit = is_div ? (opb_q == '0) : (opb_q[WIDTH-1:1] == '0);
`else
    assign early_exit = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        acc_d     = acc_q;
        araw_d    = araw_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (wr_hi) hi_d = wr_data;
                if (wr_lo) lo_d = wr_data;
                if (start) begin
                    state_d   = ST_RUN;
                    op_d      = op;
                    opa_d     = {{WIDTH{1'b0}}, a_mag};
                    opb_d     = b_mag;
                    acc_d     = '0;
                    araw_d    = a;
                    neg_res_d = sgn_launch & (a[WIDTH-1] ^ b[WIDTH-1]);
                    neg_rem_d = sgn_launch & a[WIDTH-1];
                    cnt_d     = '0;
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (is_div) begin
                    opa_d = {opa_q[2*WIDTH-1:WIDTH], opa_q[WIDTH-2:0], ~trial[WIDTH+1]};
                    acc_d = {{(WIDTH-1){1'b0}}, (trial[WIDTH+1] ? shifted : trial[WIDTH:0])};
                end else begin
                    acc_d = opb_q[0] ? (acc_q + opa_q) : acc_q;
                    opa_d = opa_q << 1;
                    opb_d = opb_q >> 1;
                end
                if ((cnt_q == CW'(WIDTH - 1)) || early_exit) state_d = ST_FIX;
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                if (is_div) begin
                    if (opb_q == '0) begin
                        lo_d = '1;
                        hi_d = araw_q;
                    end else begin
                        lo_d = quo_fix;
                        hi_d = rem_fix;
                    end
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= ST_IDLE;
            op_q      <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            acc_q     <= '0;
            araw_q    <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            acc_q     <= acc_d;
            araw_q    <= araw_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
